// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the IF port, MEM data port and shared memory bus seen by mem_bus_arbiter.
// The arbiter uses the slave modport; the environment (CPU side plus bus bridge) uses master.
interface mem_bus_arbiter_if;
  // Instruction-fetch port
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // Data (load/store) port
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // Shared bus towards the bridge
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one SRAM-like bus between instruction fetch and the MEM-stage data port.
// One outstanding transaction; data has fixed priority over inst.
// Optional anti-starvation guard for inst enabled by defining ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave mif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  typedef enum logic [1:0] {OwnNone, OwnInst, OwnData} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        grant_inst, grant_data;
  logic        pick_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starve_q;
  logic            inst_first;

  // Inst overrides data priority once data has won STARVE_LIMIT times in a row over it
  assign inst_first = mif.inst_req && (starve_q == CntW'(STARVE_LIMIT));
  assign pick_data  = mif.data_req && !inst_first;

  // Count data grants made while inst was waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (grant_inst) begin
      starve_q <= '0;
    end else if (grant_data) begin
      starve_q <= mif.inst_req ? starve_q + CntW'(1) : '0;
    end
  end
`else
  assign pick_data = mif.data_req;
`endif

  // State, owner and latched command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Arbitration and transaction sequencing
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_data) begin
          grant_data = 1'b1;
          owner_d    = OwnData;
          wr_d       = mif.data_wr;
          size_d     = mif.data_size;
          addr_d     = mif.data_addr;
          wdata_d    = mif.data_wdata;
          state_d    = StReq;
        end else if (mif.inst_req) begin
          grant_inst = 1'b1;
          owner_d    = OwnInst;
          wr_d       = 1'b0;
          size_d     = 2'b10;
          addr_d     = mif.inst_addr;
          wdata_d    = 32'h0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (mif.bus_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mif.bus_data_ok) begin
          owner_d = OwnNone;
          state_d = StIdle;
        end
      end
      default: begin
        owner_d = OwnNone;
        state_d = StIdle;
      end
    endcase
  end

  // Read data holds its last value between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      if (mif.inst_data_ok) inst_rdata_q <= mif.bus_rdata;
      if (mif.data_data_ok) data_rdata_q <= mif.bus_rdata;
    end
  end

  // Bus command and owner-routed handshakes; bus_data_ok outside WAIT is dropped here
  always_comb begin
    mif.bus_req      = (state_q == StReq);
    mif.bus_wr       = wr_q;
    mif.bus_size     = size_q;
    mif.bus_addr     = addr_q;
    mif.bus_wdata    = wdata_q;
    mif.inst_addr_ok = (state_q == StReq) && (owner_q == OwnInst) && mif.bus_addr_ok;
    mif.data_addr_ok = (state_q == StReq) && (owner_q == OwnData) && mif.bus_addr_ok;
    mif.inst_data_ok = (state_q == StWait) && (owner_q == OwnInst) && mif.bus_data_ok;
    mif.data_data_ok = (state_q == StWait) && (owner_q == OwnData) && mif.bus_data_ok;
    mif.inst_rdata   = mif.inst_data_ok ? mif.bus_rdata : inst_rdata_q;
    mif.data_rdata   = mif.data_data_ok ? mif.bus_rdata : data_rdata_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, load, priority, back-pressure, stray responses,
// starvation guard (expectation follows ARB_STARVE_GUARD_EN) and reset during WAIT.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_bus_arbiter_if mif ();

  mem_bus_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mif.inst_req    = 1'b0;
    mif.inst_addr   = 32'h0;
    mif.data_req    = 1'b0;
    mif.data_wr     = 1'b0;
    mif.data_size   = 2'b00;
    mif.data_addr   = 32'h0;
    mif.data_wdata  = 32'h0;
    mif.bus_addr_ok = 1'b0;
    mif.bus_data_ok = 1'b0;
    mif.bus_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    #1;
    checks++;
    if ({mif.bus_req, mif.bus_wr, mif.bus_size} !== 4'b0) begin
      failures++;
      $display("FAIL reset_bus_ctrl got=%b want=0000", {mif.bus_req, mif.bus_wr, mif.bus_size});
    end
    checks++;
    if ({mif.bus_addr, mif.bus_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_bus_data got=%h want=0", {mif.bus_addr, mif.bus_wdata});
    end
    checks++;
    if ({mif.inst_addr_ok, mif.inst_data_ok, mif.data_addr_ok, mif.data_data_ok} !== 4'b0) begin
      failures++;
      $display("FAIL reset_oks got=%b want=0000",
               {mif.inst_addr_ok, mif.inst_data_ok, mif.data_addr_ok, mif.data_data_ok});
    end
    checks++;
    if ({mif.inst_rdata, mif.data_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h want=0", {mif.inst_rdata, mif.data_rdata});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_load();
    // Cycle 1: IDLE sees the request
    mif.data_req  = 1'b1;
    mif.data_wr   = 1'b0;
    mif.data_size = 2'b10;
    mif.data_addr = 32'h100;
    #1;
    checks++;
    if (mif.bus_req !== 1'b0 || mif.data_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL load_idle bus_req=%b addr_ok=%b want 0 0", mif.bus_req, mif.data_addr_ok);
    end
    // Cycle 2: REQ, bus accepts at once
    step();
    mif.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if ({mif.bus_req, mif.bus_wr, mif.bus_size} !== 4'b1010 || mif.bus_addr !== 32'h100) begin
      failures++;
      $display("FAIL load_req_cmd got=%b addr=%h want=1010 addr=100",
               {mif.bus_req, mif.bus_wr, mif.bus_size}, mif.bus_addr);
    end
    checks++;
    if (mif.data_addr_ok !== 1'b1 || mif.inst_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL load_addr_ok data=%b inst=%b want 1 0", mif.data_addr_ok, mif.inst_addr_ok);
    end
    // Cycle 3: WAIT, response arrives
    step();
    mif.data_req    = 1'b0;
    mif.bus_addr_ok = 1'b0;
    mif.bus_data_ok = 1'b1;
    mif.bus_rdata   = 32'hDEADBEEF;
    #1;
    checks++;
    if (mif.data_data_ok !== 1'b1 || mif.data_rdata !== 32'hDEADBEEF || mif.inst_data_ok !== 1'b0
        || mif.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL load_data_ok ok=%b rdata=%h inst_ok=%b bus_req=%b want 1 deadbeef 0 0",
               mif.data_data_ok, mif.data_rdata, mif.inst_data_ok, mif.bus_req);
    end
    step();
    mif.bus_data_ok = 1'b0;
    mif.bus_rdata   = 32'h0;
    #1;
    checks++;
    if (mif.data_data_ok !== 1'b0 || mif.data_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_rdata_hold ok=%b rdata=%h want 0 deadbeef",
               mif.data_data_ok, mif.data_rdata);
    end
  endtask

  task automatic test_simultaneous();
    mif.inst_req   = 1'b1;
    mif.inst_addr  = 32'hBFC00000;
    mif.data_req   = 1'b1;
    mif.data_wr    = 1'b1;
    mif.data_size  = 2'b01;
    mif.data_addr  = 32'h4;
    mif.data_wdata = 32'h12345678;
    step();
    mif.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if ({mif.bus_req, mif.bus_wr, mif.bus_size} !== 4'b1101 || mif.bus_addr !== 32'h4
        || mif.bus_wdata !== 32'h12345678) begin
      failures++;
      $display("FAIL sim_store_cmd got=%b addr=%h wdata=%h want=1101 4 12345678",
               {mif.bus_req, mif.bus_wr, mif.bus_size}, mif.bus_addr, mif.bus_wdata);
    end
    checks++;
    if (mif.data_addr_ok !== 1'b1 || mif.inst_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL sim_store_addr_ok data=%b inst=%b want 1 0",
               mif.data_addr_ok, mif.inst_addr_ok);
    end
    step();
    mif.data_req    = 1'b0;
    mif.bus_addr_ok = 1'b0;
    mif.bus_data_ok = 1'b1;
    #1;
    checks++;
    if (mif.data_data_ok !== 1'b1 || mif.inst_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL sim_store_done data=%b inst=%b want 1 0", mif.data_data_ok, mif.inst_data_ok);
    end
    // IDLE: inst wins the new arbitration
    step();
    mif.bus_data_ok = 1'b0;
    #1;
    checks++;
    if (mif.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL sim_idle_gap bus_req=%b want 0", mif.bus_req);
    end
    step();
    mif.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if ({mif.bus_req, mif.bus_wr, mif.bus_size} !== 4'b1010 || mif.bus_addr !== 32'hBFC00000
        || mif.inst_addr_ok !== 1'b1 || mif.data_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL sim_inst_cmd got=%b addr=%h iok=%b dok=%b want=1010 bfc00000 1 0",
               {mif.bus_req, mif.bus_wr, mif.bus_size}, mif.bus_addr,
               mif.inst_addr_ok, mif.data_addr_ok);
    end
    step();
    mif.inst_req    = 1'b0;
    mif.bus_addr_ok = 1'b0;
    mif.bus_data_ok = 1'b1;
    mif.bus_rdata   = 32'h0BADF00D;
    #1;
    checks++;
    if (mif.inst_data_ok !== 1'b1 || mif.inst_rdata !== 32'h0BADF00D
        || mif.data_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL sim_inst_data iok=%b rdata=%h dok=%b want 1 0badf00d 0",
               mif.inst_data_ok, mif.inst_rdata, mif.data_data_ok);
    end
    step();
    mif.bus_data_ok = 1'b0;
    mif.bus_rdata   = 32'h0;
  endtask

  task automatic test_back_pressure();
    mif.data_req   = 1'b1;
    mif.data_wr    = 1'b1;
    mif.data_size  = 2'b10;
    mif.data_addr  = 32'h200;
    mif.data_wdata = 32'hAAAA5555;
    step();
    for (int i = 0; i < 5; i++) begin
      mif.data_addr  = 32'h300 + 32'(i);
      mif.data_wdata = 32'h1111 * 32'(i + 1);
      #1;
      checks++;
      if (mif.bus_req !== 1'b1 || mif.bus_addr !== 32'h200 || mif.bus_wdata !== 32'hAAAA5555
          || mif.data_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] req=%b addr=%h wdata=%h aok=%b want 1 200 aaaa5555 0",
                 i, mif.bus_req, mif.bus_addr, mif.bus_wdata, mif.data_addr_ok);
      end
      step();
    end
    mif.bus_addr_ok = 1'b1;
    #1;
    checks++;
    if (mif.data_addr_ok !== 1'b1 || mif.bus_addr !== 32'h200) begin
      failures++;
      $display("FAIL bp_accept aok=%b addr=%h want 1 200", mif.data_addr_ok, mif.bus_addr);
    end
    step();
    mif.data_req    = 1'b0;
    mif.bus_addr_ok = 1'b0;
    #1;
    checks++;
    if (mif.data_addr_ok !== 1'b0 || mif.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL bp_wait aok=%b req=%b want 0 0", mif.data_addr_ok, mif.bus_req);
    end
    mif.bus_data_ok = 1'b1;
    step();
    mif.bus_data_ok = 1'b0;
  endtask

  task automatic test_stray_idle();
    mif.bus_data_ok = 1'b1;
    mif.bus_rdata   = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({mif.inst_data_ok, mif.data_data_ok, mif.bus_req} !== 3'b0) begin
        failures++;
        $display("FAIL stray_idle[%0d] got=%b want=000", i,
                 {mif.inst_data_ok, mif.data_data_ok, mif.bus_req});
      end
      step();
    end
    mif.bus_data_ok = 1'b0;
    mif.bus_rdata   = 32'h0;
  endtask

  task automatic test_starve();
    logic exp_inst;
    logic got_inst;
    bit   found;
    mif.inst_req  = 1'b1;
    mif.inst_addr = 32'hBFC00000;
    mif.data_req  = 1'b1;
    mif.data_wr   = 1'b0;
    mif.data_size = 2'b10;
    mif.data_addr = 32'h40;
    for (int t = 0; t < 6; t++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_inst = (t == 4);
`else
      exp_inst = 1'b0;
`endif
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        step();
        if (mif.bus_req === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL starve_timeout[%0d] bus_req=0 want 1", t);
      end else begin
        got_inst = (mif.bus_addr == 32'hBFC00000);
        mif.bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (got_inst !== exp_inst || mif.inst_addr_ok !== exp_inst
            || mif.data_addr_ok !== !exp_inst) begin
          failures++;
          $display("FAIL starve_grant[%0d] inst=%b iok=%b dok=%b want inst=%b",
                   t, got_inst, mif.inst_addr_ok, mif.data_addr_ok, exp_inst);
        end
        step();
        mif.bus_addr_ok = 1'b0;
        mif.bus_data_ok = 1'b1;
        step();
        mif.bus_data_ok = 1'b0;
      end
    end
    mif.inst_req = 1'b0;
    mif.data_req = 1'b0;
    step();
  endtask

  task automatic test_reset_in_wait();
    mif.data_req  = 1'b1;
    mif.data_wr   = 1'b0;
    mif.data_size = 2'b10;
    mif.data_addr = 32'h80;
    step();
    mif.bus_addr_ok = 1'b1;
    step();
    mif.data_req    = 1'b0;
    mif.bus_addr_ok = 1'b0;
    mif.bus_rdata   = 32'h55AA55AA;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mif.bus_data_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({mif.inst_data_ok, mif.data_data_ok, mif.inst_addr_ok, mif.data_addr_ok} !== 4'b0
          || mif.bus_req !== 1'b0) begin
        failures++;
        $display("FAIL rst_wait_oks[%0d] got=%b bus_req=%b want 0000 0", i,
                 {mif.inst_data_ok, mif.data_data_ok, mif.inst_addr_ok, mif.data_addr_ok},
                 mif.bus_req);
      end
      checks++;
      if ({mif.bus_addr, mif.bus_wdata, mif.bus_wr, mif.bus_size} !== 67'h0
          || {mif.inst_rdata, mif.data_rdata} !== 64'h0) begin
        failures++;
        $display("FAIL rst_wait_zero[%0d] addr=%h rdata=%h/%h want 0", i,
                 mif.bus_addr, mif.inst_rdata, mif.data_rdata);
      end
      step();
    end
    mif.bus_data_ok = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_single_load();
    test_simultaneous();
    test_back_pressure();
    test_stray_idle();
    test_starve();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port and the data (load/store) port of the MEM stage.
- Grants one requester at a time and latches its command onto the bus.
- Tracks the single outstanding transaction and routes `addr_ok`/`data_ok`/`rdata` back to the owner.
- Sits between the IF/MEM-stage memory interfaces and the top-level bus bridge.

Parameters:
- STARVE_LIMIT, 4, number of consecutive data grants allowed while an inst request is pending (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  instruction read request; held high until inst_addr_ok
- inst_addr  in  32  fetch address, word aligned
- inst_addr_ok  out  1  inst command accepted by bus
- inst_data_ok  out  1  inst read data valid
- inst_rdata  out  32  inst read data
- data_req  in  1  data request; held high with stable fields until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  00 byte, 01 half, 10 word
- data_addr  in  32  data byte address
- data_wdata  in  32  store data, already lane-aligned
- data_addr_ok  out  1  data command accepted
- data_data_ok  out  1  load data valid / store completed
- data_rdata  out  32  load data
- bus_req  out  1  bus command valid
- bus_wr  out  1  bus write enable
- bus_size  out  2  bus access size
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_addr_ok  in  1  bus accepted command
- bus_data_ok  in  1  bus response valid
- bus_rdata  in  32  bus read data

Behaviour:
- Reset (rst high at posedge):
  - State IDLE, owner=NONE, starve counter=0.
  - All bus_* outputs 0; all *_addr_ok and *_data_ok 0; rdata outputs 0.
  - Reset mid-transaction abandons it; any later bus_data_ok seen in IDLE is dropped.
- FSM states: IDLE, REQ, WAIT. At most one outstanding transaction.
- IDLE:
  - If data_req or inst_req, select winner; data has fixed priority over inst.
  - Latch owner and command into registers: inst forces wr=0, size=10. Next state REQ.
  - No requests: stay IDLE.
- REQ:
  - bus_req=1; bus_wr, bus_size, bus_addr, bus_wdata driven from the latched registers, stable for the whole state.
  - When bus_addr_ok=1, pulse the owner's *_addr_ok in the same cycle (combinational pass-through), then go to WAIT.
  - Owner never changes while in REQ.
- WAIT:
  - bus_req=0.
  - When bus_data_ok=1, the owner's *_data_ok=1 in the same cycle and *_rdata=bus_rdata; next state IDLE.
  - The non-owner's ok outputs stay 0.
- Response routing:
  - bus_data_ok in IDLE or REQ is ignored.
  - *_rdata hold their last value when the matching data_ok is 0.
- Timing:
  - Minimum transaction: IDLE→REQ (1 cycle), REQ with same-cycle addr_ok (1 cycle), WAIT with same-cycle data_ok (1 cycle) = 3 cycles request-to-data_ok.
  - New arbitration occurs in the IDLE cycle after completion.
- Simultaneous requests: data wins, inst waits in IDLE for the next arbitration. A requester's req staying high after its addr_ok is treated as a new request.
- Writes: store completion is signalled by data_data_ok; data_rdata is don't-care.

Optional Feature:
- ARB_STARVE_GUARD_EN
- Defined:
  - Counter increments on each data grant made while inst_req=1; clears on any inst grant, or on a data grant with inst_req=0.
  - When counter==STARVE_LIMIT and inst_req=1, the next IDLE arbitration grants inst even if data_req=1.
- Undefined: pure fixed data priority; counter logic absent.

Test Plan:
- Single load: data_req, addr=0x100, size=10; bus_addr_ok in REQ, bus_data_ok one cycle later with 0xDEADBEEF -> data_addr_ok cycle 2, data_data_ok cycle 3, data_rdata=0xDEADBEEF; inst ok outputs stay 0.
- Simultaneous inst_req (addr 0xBFC00000) and data store (addr 0x4, wdata 0x12345678, size 01) -> bus shows store first (bus_wr=1, size 01); inst granted in the IDLE after data_data_ok, with bus_wr=0, size 10.
- Back-pressure: bus_addr_ok held 0 for 5 cycles in REQ while inputs change -> bus_addr/bus_wdata unchanged throughout; addr_ok only on the accepting cycle.
- Reset in WAIT: assert rst, then bus_data_ok=1 the next cycle -> no *_data_ok pulse, state IDLE, all outputs 0.
- Stray bus_data_ok in IDLE -> ignored, no ok pulses.
- With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, data_req and inst_req both held high -> 4 data grants, then 1 inst grant, then data resumes; without the macro, inst is never granted while data_req=1.
